// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and a width-agnostic conditional two's-complement negate.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   // Widest value cond_neg handles; callers zero-extend in and truncate out.
   localparam int unsigned NEG_MAX_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Low-order bits of the result are correct for any narrower call-site width.
   function automatic logic [NEG_MAX_W-1:0] cond_neg(input logic [NEG_MAX_W-1:0] x,
                                                     input logic en);
      return en ? (~x + NEG_MAX_W'(1)) : x;
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide unit holding the CPU's HI/LO registers.
// One shift-add or restoring-divide step per clock; WIDTH+1 cycles per operation.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   state_t               state, state_nxt;
   logic                 busy_nxt, done_nxt;
   logic [CW-1:0]        cnt;

   logic                 div_q;
   logic                 neg_q;
   logic                 neg_r;
   logic                 dz_q;
   logic [WIDTH-1:0]     raw_a;
   logic [WIDTH-1:0]     opa;
   logic [WIDTH-1:0]     opb;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     hi_q, lo_q;

   logic                 sgn_in;
   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   always_comb begin
      sgn_in    = ~op[0];
      a_abs     = WIDTH'(cond_neg(NEG_MAX_W'(a), sgn_in & a[WIDTH-1]));
      b_abs     = WIDTH'(cond_neg(NEG_MAX_W'(b), sgn_in & b[WIDTH-1]));
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : '0);
      div_shift = {rem, quo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb};
      prod_fix  = (2*WIDTH)'(cond_neg(NEG_MAX_W'(prod), neg_q));
      quo_fix   = WIDTH'(cond_neg(NEG_MAX_W'(quo), neg_q));
      rem_fix   = WIDTH'(cond_neg(NEG_MAX_W'(rem), neg_r));
   end

   always_comb begin
      state_nxt = state;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_CALC;
               busy_nxt  = 1'b1;
            end
         end
         ST_CALC: begin
            if (cancel) begin
               state_nxt = ST_IDLE;
            end else begin
               busy_nxt = 1'b1;
               if (cnt == LAST_STEP) state_nxt = ST_FIX;
            end
         end
         ST_FIX: begin
            state_nxt = ST_IDLE;
            done_nxt  = ~cancel;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         div_q <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz_q  <= 1'b0;
         raw_a <= '0;
         opa   <= '0;
         opb   <= '0;
         prod  <= '0;
         rem   <= '0;
         quo   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hi_we) hi_q <= wdata;
               if (lo_we) lo_q <= wdata;
               if (start) begin
                  cnt   <= '0;
                  div_q <= op[1];
                  neg_q <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r <= sgn_in & a[WIDTH-1];
                  dz_q  <= (b == '0);
                  raw_a <= a;
                  opa   <= a_abs;
                  opb   <= b_abs;
                  prod  <= {{WIDTH{1'b0}}, b_abs};
                  rem   <= '0;
                  quo   <= a_abs;
               end
            end
            ST_CALC: begin
               if (!cancel) begin
                  cnt <= cnt + CW'(1);
                  if (div_q) begin
                     // Restore by keeping the unsubtracted value when the trial goes negative.
                     rem <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], ~div_diff[WIDTH]};
                  end else begin
                     prod <= {mul_sum, prod[WIDTH-1:1]};
                  end
               end
            end
            ST_FIX: begin
               if (!cancel) begin
                  if (div_q) begin
                     if (dz_q) begin
                        hi_q <= raw_a;
                        lo_q <= '1;
                     end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                     end
                  end else begin
                     hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                     lo_q <= prod_fix[WIDTH-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, cancel, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   logic        s8_start, s8_cancel, s8_hi_we, s8_lo_we;
   logic [1:0]  s8_op;
   logic [7:0]  s8_a, s8_b, s8_wdata;
   logic        s8_busy, s8_done;
   logic [7:0]  s8_hi, s8_lo;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   muldiv_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(s8_start), .op(s8_op), .a(s8_a), .b(s8_b),
      .cancel(s8_cancel), .hi_we(s8_hi_we), .lo_we(s8_lo_we), .wdata(s8_wdata),
      .busy(s8_busy), .done(s8_done), .hi(s8_hi), .lo(s8_lo)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents an op for one edge (E0) and returns just after it.
   task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Returns on the done cycle; busy_cyc counts busy cycles seen on the way.
   task automatic wait_done(output int unsigned busy_cyc, output logic ok);
      busy_cyc = 0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (busy) busy_cyc++;
         if (done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      int unsigned bc;
      logic ok;
      start_op(o, x, y);
      wait_done(bc, ok);
      check_eq({tag, "_done"}, ok, 1);
      check_eq({tag, "_busy_cycles"}, bc, 33);
      check_eq({tag, "_hi"}, hi, exp_hi);
      check_eq({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      int unsigned bc;
      int unsigned n_done;
      logic ok;

      rst = 1'b1; start = 0; cancel = 0; hi_we = 0; lo_we = 0;
      op = 0; a = 0; b = 0; wdata = 0;
      s8_start = 0; s8_cancel = 0; s8_hi_we = 0; s8_lo_we = 0;
      s8_op = 0; s8_a = 0; s8_b = 0; s8_wdata = 0;
      #12;
      check_eq("rst_hi", hi, 0);
      check_eq("rst_lo", lo, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      rst = 1'b0;
      tick();

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      tick();
      check_eq("multu_max_done_pulse", done, 0);
      check_eq("multu_max_idle", busy, 0);

      run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_negdiv", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
      run_op("divu_basic", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
      run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run_op("div_mn", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

      // mtlo then cancelled mult: hi stays 0 from div_mn, lo keeps 0x1234
      tick();
      lo_we = 1'b1; wdata = 32'h1234;
      tick();
      lo_we = 1'b0;
      check_eq("mtlo", lo, 32'h1234);
      start_op(2'b00, 32'd6, 32'd7);
      for (int i = 0; i < 9; i++) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check_eq("cancel_idle", busy, 0);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) n_done++;
         tick();
      end
      check_eq("cancel_no_done", n_done, 0);
      check_eq("cancel_hi", hi, 0);
      check_eq("cancel_lo", lo, 32'h1234);

      // Asynchronous reset mid-CALC
      start_op(2'b00, 32'd6, 32'd7);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      #2;
      check_eq("rstmid_hi", hi, 0);
      check_eq("rstmid_lo", lo, 0);
      check_eq("rstmid_busy", busy, 0);
      rst = 1'b0;
      tick();

      // start and hi_we while busy are both dropped
      start_op(2'b01, 32'd6, 32'd7);
      tick(); tick();
      start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
      hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      tick();
      start = 1'b0; hi_we = 1'b0;
      check_eq("busy_hi_we_ignored", hi, 0);
      wait_done(bc, ok);
      check_eq("busy_ign_done", ok, 1);
      check_eq("busy_ign_hi", hi, 0);
      check_eq("busy_ign_lo", lo, 32'd42);
      tick();
      check_eq("busy_ign_no_queue", busy, 0);

      // Back-to-back: second start on the done cycle of the first
      start_op(2'b01, 32'd3, 32'd4);
      wait_done(bc, ok);
      check_eq("b2b_first_done", ok, 1);
      check_eq("b2b_first_lo", lo, 32'd12);
      start_op(2'b11, 32'd100, 32'd7);
      check_eq("b2b_accepted", busy, 1);
      wait_done(bc, ok);
      check_eq("b2b_second_done", ok, 1);
      check_eq("b2b_second_hi", hi, 32'd2);
      check_eq("b2b_second_lo", lo, 32'd14);

      // mthi together with start in IDLE: write lands, op still runs
      hi_we = 1'b1; wdata = 32'h0000_ABCD;
      start_op(2'b01, 32'd2, 32'd3);
      hi_we = 1'b0;
      check_eq("we_start_hi", hi, 32'h0000_ABCD);
      check_eq("we_start_busy", busy, 1);
      wait_done(bc, ok);
      check_eq("we_start_done", ok, 1);
      check_eq("we_start_res_hi", hi, 0);
      check_eq("we_start_res_lo", lo, 32'd6);

      // WIDTH=8 instance
      s8_op = 2'b01; s8_a = 8'hFF; s8_b = 8'hFF; s8_start = 1'b1;
      tick();
      s8_start = 1'b0;
      bc = 0; ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (s8_busy) bc++;
         if (s8_done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check_eq("w8_done", ok, 1);
      check_eq("w8_busy_cycles", bc, 9);
      check_eq("w8_hi", s8_hi, 8'hFE);
      check_eq("w8_lo", s8_lo, 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Parametrised, iterative multiply/divide unit with HI/LO registers. It replaces the combinational multiplier/divider and the separate HI/LO registers in the multi-cycle CPU datapath. One radix-2 shift-add or restoring-divide step runs per clock. A `busy` output lets the control unit stall `mfhi`/`mflo`, `mthi`/`mtlo` and new mul/div instructions while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 4.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  accept operation when idle.
- `op`  in  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- `a`  in  WIDTH  rs operand (multiplicand / dividend).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `cancel`  in  1  abort in-flight operation (exception/eret).
- `hi_we`  in  1  mthi write.
- `lo_we`  in  1  mtlo write.
- `wdata`  in  WIDTH  data for `hi_we`/`lo_we`.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse: HI/LO just updated by an operation.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - `start`=1 latches `op`, |a|, |b| (magnitude only for signed ops), result sign flags and a zero-divisor flag.
  - Clears the step counter and moves to CALC.
- CALC:
  - Performs one iteration per cycle for exactly WIDTH cycles, then moves to FIX.
  - Counter width is $clog2(WIDTH+1).
- Multiply:
  - 2·WIDTH-bit product register, shift-add on the LSB of the multiplier.
- Divide:
  - Restoring algorithm, WIDTH+1-bit partial remainder; quotient bits are shifted in at the LSB.
- FIX:
  - Applies sign correction, writes HI/LO, pulses `done`, returns to IDLE.
- Signed multiply:
  - Negate the 2·WIDTH product if operand signs differ.
  - HI = upper WIDTH bits, LO = lower WIDTH bits.
- Signed divide:
  - Quotient is negated if operand signs differ.
  - Remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Boundary cases:
  - Most-negative ÷ −1: LO = most-negative, HI = 0 (wraps, no trap).
  - Divisor zero (any div op): LO = all ones, HI = raw `a`, no sign fix. Same latency as a normal divide.
- `start` while busy: ignored, no queueing.
- `cancel` in CALC or FIX:
  - Returns to IDLE next edge.
  - HI/LO unchanged, no `done`.
  - `cancel` has priority over a FIX write in the same cycle.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE; ignored while `busy`.
  - In IDLE with `start` also high, the write happens and the operation still starts. Its result later overwrites HI/LO.
- `rst`:
  - Forces IDLE immediately, mid-operation included.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0; counter and internal registers cleared.

## Timing
- Accept edge E0: `busy` is high from just after E0.
- Edges E1..EWIDTH perform the iterations.
- Edge EWIDTH+1 (FIX) writes HI/LO.
- `busy` is high for exactly WIDTH+1 cycles; total latency is WIDTH+1 edges after acceptance.
- `done` and the new `hi`/`lo` are visible in the cycle after EWIDTH+1. `busy` is low in that same cycle, so a back-to-back `start` is accepted on the `done` cycle.
- `hi`/`lo` are registered outputs and change only on write edges.
- `busy` and `done` are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `muldiv_pkg`:
  - `op` encoding constants: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State enum: ST_IDLE, ST_CALC, ST_FIX.
- Single module; no sub-module needed.
- Negation/abs is a local function in the package, parametrised by width through its call sites.
- HI/LO registers live inside this block; the CPU's separate HI and LO register instances and their write-select muxes are removed.

## Test plan
All scenarios use WIDTH=32 unless noted.
- multu 0xFFFFFFFF × 0xFFFFFFFF → after 33 edges, hi=0xFFFFFFFE, lo=0x00000001, `done` for 1 cycle, `busy` high exactly 33 cycles.
- mult −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also div −7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100 ÷ 0 → lo=0xFFFFFFFF, hi=0x00000064. Also div 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- Cancel paths:
  - `start` mult 6 × 7 after an mtlo of 0x1234; `cancel` at iteration 10 → idle next cycle, no `done`, hi/lo keep prior values (lo=0x1234).
  - Repeat with `rst` pulsed mid-CALC → hi=lo=0 immediately.
- `start` and `hi_we` asserted during `busy` → both ignored, result matches the first operation.
- Back-to-back `start` on the `done` cycle is accepted.
- Rerun the first scenario at WIDTH=8: 0xFF × 0xFF → hi=0xFE, lo=0x01 after 9 edges.
